// File: rtl/somador_serial_4bits.sv
// Bit-serial adder, LSB first: one full-adder step per clock through a carry
// flip-flop, with the result shifted in from the MSB side.
module somador_serial_4bits #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] soma,
    output logic             carry,
    output logic             busy,
    output logic             done
);

    // One extra counter bit so the count never wraps during an operation.
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   res_q;
    logic               cy_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   soma_q;
    logic               carry_q;
    logic               busy_q;
    logic               done_q;

    logic [1:0]         fa_d;
    logic [WIDTH-1:0]   res_d;
    logic               last_d;

    // Returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

    // Full-adder step on the current LSBs and the result with the new sum bit at the MSB.
    always_comb begin
        fa_d             = full_add(a_q[0], b_q[0], cy_q);
        res_d            = res_q >> 1'b1;
        res_d[WIDTH-1]   = fa_d[0];
        last_d           = (cnt_q == CNT_W'(WIDTH - 1));
    end

    // Control FSM, datapath shift registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cy_q    <= 1'b0;
            cnt_q   <= '0;
            soma_q  <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_q     <= A;
                        b_q     <= B;
                        res_q   <= '0;
                        cy_q    <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= ST_SHIFT;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                    done_q <= 1'b0;
                end
                ST_SHIFT: begin
                    a_q   <= a_q >> 1'b1;
                    b_q   <= b_q >> 1'b1;
                    res_q <= res_d;
                    cy_q  <= fa_d[1];
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_d) begin
                        soma_q  <= res_d;
                        carry_q <= fa_d[1];
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ST_SHIFT;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign soma  = soma_q;
    assign carry = carry_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_somador_serial_4bits.sv
// Randomized bench for the serial adder against a cycle-count/arithmetic model,
// with directed literal checks for the known corner cases.
module tb_somador_serial_4bits;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic [WIDTH-1:0] soma;
    logic             carry;
    logic             busy;
    logic             done;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    // Reference model: remaining SHIFT cycles, done flag, pending WIDTH+1-bit sum.
    int               m_left = 0;
    bit               m_done = 1'b0;
    logic [WIDTH-1:0] m_soma = '0;
    logic             m_carry = 1'b0;
    logic [WIDTH:0]   m_pend = '0;

    somador_serial_4bits #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .soma  (soma),
        .carry (carry),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_left  <= 0;
            m_done  <= 1'b0;
            m_soma  <= '0;
            m_carry <= 1'b0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done  <= 1'b1;
                m_soma  <= m_pend[WIDTH-1:0];
                m_carry <= m_pend[WIDTH];
            end
        end else if (start) begin
            m_left <= WIDTH;
            m_pend <= {1'b0, A} + {1'b0, B};
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_soma",  32'(soma),  32'(m_soma));
            chk("cyc_carry", 32'(carry), 32'(m_carry));
            chk("cyc_busy",  32'(busy),  32'(m_left > 0));
            chk("cyc_done",  32'(done),  32'(m_done));
        end
    end

    // Start one addition, scramble A/B while it runs, then check its result.
    task automatic op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [WIDTH-1:0] exp_s, input logic exp_c, input string nm);
        int  busy_cnt = 0;
        bit  got = 1'b0;
        @(negedge clk);
        A = a; B = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (done) begin
                got = 1'b1;
            end else begin
                if (busy) busy_cnt++;
                A = WIDTH'($urandom);
                B = WIDTH'($urandom);
                @(negedge clk);
            end
        end
        chk({nm, "_done_seen"}, 32'(got), 32'd1);
        chk({nm, "_soma"},  32'(soma),  32'(exp_s));
        chk({nm, "_carry"}, 32'(carry), 32'(exp_c));
        chk({nm, "_busy_len"}, 32'(busy_cnt), 32'(WIDTH));
    endtask

    initial begin
        int n_done;
        int busy_after;
        logic [WIDTH:0] s;

        // Reset
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        @(negedge clk); rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_soma",  32'(soma),  32'd0);
        chk("rst_carry", 32'(carry), 32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_done",  32'(done),  32'd0);

        // Basic and wrap-around cases
        op(4'd3,  4'd5,  4'd8,  1'b0, "basic");
        op(4'd15, 4'd1,  4'd0,  1'b1, "wrap1");
        op(4'd15, 4'd15, 4'd14, 1'b1, "wrap2");
        op(4'd0,  4'd0,  4'd0,  1'b0, "zero");

        // Inverse of the subtractor, all X, Y
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                s = 5'(((x - y) & 15) + y);
                op(4'((x - y) & 15), 4'(y), 4'(x), s[WIDTH], "inverse");
            end
        end

        // start pulses during SHIFT and DONE are ignored
        @(negedge clk); A = 4'd7; B = 4'd2; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); A = 4'd1; B = 4'd1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        n_done = 0;
        busy_after = 0;
        for (int i = 0; i < 16; i++) begin
            if (done) begin
                n_done++;
                chk("ignore_soma", 32'(soma), 32'd9);
                A = 4'd1; B = 4'd1; start = 1'b1;
            end else begin
                if (n_done > 0 && busy) busy_after++;
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("ignore_done_cnt", 32'(n_done), 32'd1);
        chk("ignore_no_busy", 32'(busy_after), 32'd0);

        // Reset in the middle of an operation
        @(negedge clk); A = 4'd9; B = 4'd9; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("abort_soma",  32'(soma),  32'd0);
        chk("abort_carry", 32'(carry), 32'd0);
        chk("abort_busy",  32'(busy),  32'd0);
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) n_done++;
            @(negedge clk);
        end
        chk("abort_no_done", 32'(n_done), 32'd0);
        op(4'd2, 4'd3, 4'd5, 1'b0, "after_abort");

        // Result holds while inputs move with start low
        op(4'd3, 4'd5, 4'd8, 1'b0, "hold_setup");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            A = WIDTH'($urandom); B = WIDTH'($urandom); start = 1'b0;
        end
        @(negedge clk);
        chk("hold_soma",  32'(soma),  32'd8);
        chk("hold_carry", 32'(carry), 32'd0);
        chk("hold_done",  32'(done),  32'd0);

        // Fully random traffic including occasional resets
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            A     = WIDTH'($urandom);
            B     = WIDTH'($urandom);
            start = ($urandom_range(0, 3) == 0);
            rst   = ($urandom_range(0, 60) == 0);
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        repeat (8) @(negedge clk);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/somador_serial_4bits.md
SOMADOR_SERIAL_4BITS -- requirements
Module: somador_serial_4bits

Interface
REQ-001 Parameter: WIDTH, default 4, operand and result width in bits.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset; synchronous and active-high.
REQ-004 Port: start  input  1  request to begin an addition; sampled on the clk rising edge.
REQ-005 Port: A  input  WIDTH  first operand (typically a subtractor difference), unsigned / two's-complement bit pattern.
REQ-006 Port: B  input  WIDTH  second operand (typically the subtractor subtrahend).
REQ-007 Port: soma  output  WIDTH  result (A+B) mod 2^WIDTH.
REQ-008 Port: carry  output  1  carry-out of the WIDTH-bit addition.
REQ-009 Port: busy  output  1  high while a computation is in progress.
REQ-010 Port: done  output  1  one-cycle pulse marking soma/carry valid.

Function
REQ-011 The block SHALL be the inverse companion of the 4-bit two's-complement subtractor: for any X, Y, feeding A=(X-Y) mod 2^WIDTH, B=Y SHALL yield soma=X.
REQ-012 Addition SHALL be bit-serial, LSB first: one full-adder evaluation per clock, with a 1-bit carry flip-flop and shift registers for A, B and the result.
REQ-013 FSM states SHALL be IDLE, SHIFT and DONE; the encoding is free.
REQ-014 IDLE: on an edge with start=1, capture A and B into the shift registers, clear the carry flip-flop to 0, clear the bit counter to 0, and go to SHIFT; with start=0, stay in IDLE.
REQ-015 SHIFT: each edge adds the current LSBs plus the carry flip-flop, shifts the sum bit into the result register from the MSB side, updates the carry flip-flop and increments the counter.
REQ-016 SHIFT SHALL go to DONE on the edge that processes bit WIDTH-1, making exactly WIDTH SHIFT edges.
REQ-017 DONE: soma and carry SHALL be updated on entry; one edge later the FSM SHALL return to IDLE unconditionally.
REQ-018 busy SHALL be 1 exactly while in SHIFT.
REQ-019 done SHALL be 1 exactly while in DONE, giving a one-cycle pulse.
REQ-020 Latency: with start accepted at edge k, done SHALL be high during the cycle after edge k+WIDTH and soma/carry SHALL be valid from then on.
REQ-021 soma and carry SHALL hold their last result through IDLE and through a following SHIFT; they SHALL change only on entry to DONE or on reset.
REQ-022 start SHALL be ignored in SHIFT and in DONE; it is not queued, and the captured operands are unaffected.
REQ-023 Changes on A and B after capture SHALL NOT affect the result in progress.
REQ-024 The counter SHALL be ceil(log2(WIDTH))+1 bits wide so that it never wraps during an operation.
REQ-025 Arithmetic SHALL be modular: overflow beyond WIDTH bits appears only on carry, and soma wraps (e.g. 15+1 gives soma=0, carry=1).

Reset
REQ-026 On a clk edge with rst=1, the block SHALL go to IDLE and set soma=0, carry=0, busy=0 and done=0, with the internal registers and counter cleared.
REQ-027 rst SHALL take priority over start and over every FSM transition.
REQ-028 A reset during SHIFT SHALL abort the operation with no done pulse, and the operands SHALL be discarded.
REQ-029 After reset, the first edge with start=1 SHALL be accepted normally.

Verification
REQ-030 Basic: rst 2 cycles, then A=3, B=5, start 1 cycle -> busy high for 4 cycles, then done pulse with soma=8, carry=0.
REQ-031 Wrap-around: A=15, B=1 -> soma=0, carry=1. A=15, B=15 -> soma=14, carry=1. A=0, B=0 -> soma=0, carry=0.
REQ-032 Inverse property, exhaustive: for all X, Y in 0..15, drive A=(X-Y) mod 16, B=Y -> soma=X at every done pulse; 256 checks with zero mismatches; log formatted lines; dump wave.vcd.
REQ-033 Busy and done behaviour: start A=7, B=2; pulse start again with A=1, B=1 during SHIFT and again during DONE -> single done pulse with soma=9; busy never re-asserts without a new start in IDLE.
REQ-034 Reset mid-operation: start A=9, B=9, assert rst on the 2nd SHIFT cycle -> no done pulse, soma=0, carry=0, busy=0; next start A=2, B=3 -> soma=5 after 4 SHIFT cycles.
REQ-035 Hold: after a result of soma=8, change A and B with start=0 for 10 cycles -> soma, carry and done remain unchanged.
